cavlc_scan_ctrl: RTL and testbench

- Sequencer at the front of the CAVLC encoder.
- Accepts one 4x4 block of quantised coefficients in scan order over a valid/ready handshake and buffers it.
- Runs a 16-cycle reverse scan that produces the block summary: TotalCoeff, TrailingOnes and TotalZeros.
- Then streams each nonzero coefficient, highest scan index first, with its run_before and zeros_left, to the level/run encoders.

---
 rtl/cavlc_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cavlc_scan_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_scan_ctrl.sv
// cavlc_scan_ctrl
//   Front-end sequencer of the CAVLC encoder. Buffers one 4x4 block of
//   quantised coefficients (scan order), reverse-scans it in 16 cycles to
//   form the block summary, then streams every nonzero coefficient, highest
//   scan index first, with its run_before and zeros_left.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous abort back to IDLE (wins over handshakes)
//   blk_valid/ready     block input handshake, blk_data holds coef k at
//                       [k*DATA_W +: DATA_W], k=0 scanned first
//   sum_valid/ready     summary handshake: total_coeff, trailing_ones,
//                       total_zeros
//   coef_valid/ready    coefficient beat handshake: coef_level, coef_idx,
//                       coef_run_before, coef_zeros_left, coef_last
module cavlc_scan_ctrl #(
  parameter int DATA_W   = 15,
  parameter int NUM_COEF = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [NUM_COEF*DATA_W-1:0] blk_data,
  output logic                       sum_valid,
  input  logic                       sum_ready,
  output logic [4:0]                 total_coeff,
  output logic [1:0]                 trailing_ones,
  output logic [3:0]                 total_zeros,
  output logic                       coef_valid,
  input  logic                       coef_ready,
  output logic [DATA_W-1:0]          coef_level,
  output logic [3:0]                 coef_idx,
  output logic [3:0]                 coef_run_before,
  output logic [3:0]                 coef_zeros_left,
  output logic                       coef_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_SUM  = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  localparam logic [DATA_W-1:0] PLUS_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]                 state;
  logic [NUM_COEF*DATA_W-1:0] blk_buf;
  logic [3:0]                 p;
  logic [4:0]                 tc;
  logic [1:0]                 t1;
  logic [3:0]                 tz;
  logic                       seen;
  logic                       t1_stop;
  logic [3:0]                 last_idx;
  logic [15:0]                nz;
  logic [3:0]                 zl;

  logic [DATA_W-1:0]          cur;
  logic                       cur_nz;
  logic                       cur_pm1;
  logic [3:0]                 hi;
  logic                       found;
  logic [3:0]                 run;
  logic                       is_last;

  assign cur     = blk_buf[p*DATA_W +: DATA_W];
  assign cur_nz  = (cur != '0);
  assign cur_pm1 = (cur == PLUS_ONE) || (cur == '1);

  // Highest nonzero position strictly below p; run_before is the gap to it,
  // or the distance to index 0 when p is the lowest nonzero.
  always_comb begin
    found = 1'b0;
    hi    = '0;
    for (int unsigned i = 0; i < NUM_COEF; i++) begin
      if (i < 32'(p) && nz[i]) begin
        found = 1'b1;
        hi    = 4'(i);
      end
    end
    run     = found ? (p - hi - 4'd1) : p;
    is_last = !found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      blk_buf  <= '0;
      p        <= '0;
      tc       <= '0;
      t1       <= '0;
      tz       <= '0;
      seen     <= 1'b0;
      t1_stop  <= 1'b0;
      last_idx <= '0;
      nz       <= '0;
      zl       <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_valid) begin
            blk_buf  <= blk_data;
            tc       <= '0;
            t1       <= '0;
            tz       <= '0;
            seen     <= 1'b0;
            t1_stop  <= 1'b0;
            last_idx <= '0;
            nz       <= '0;
            p        <= 4'd15;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (cur_nz) begin
            tc    <= tc + 5'd1;
            nz[p] <= 1'b1;
            if (!seen) begin
              seen     <= 1'b1;
              last_idx <= p;
            end
            if (!t1_stop && cur_pm1 && t1 != 2'd3) t1 <= t1 + 2'd1;
            else t1_stop <= 1'b1;
          end else if (seen) begin
            tz <= tz + 4'd1;
          end
          if (p == 4'd0) state <= S_SUM;
          else p <= p - 4'd1;
        end
        S_SUM: begin
          if (sum_ready) begin
            if (tc == 5'd0) begin
              state <= S_IDLE;
            end else begin
              p     <= last_idx;
              zl    <= tz;
              state <= S_EMIT;
            end
          end
        end
        default: begin
          if (!nz[p]) begin
            p <= p - 4'd1;
          end else if (coef_ready) begin
            zl <= zl - run;
            if (is_last) state <= S_IDLE;
            else p <= p - 4'd1;
          end
        end
      endcase
    end
  end

  assign blk_ready       = (state == S_IDLE);
  assign sum_valid       = (state == S_SUM);
  assign total_coeff     = sum_valid ? tc : '0;
  assign trailing_ones   = sum_valid ? t1 : '0;
  assign total_zeros     = sum_valid ? tz : '0;

  assign coef_valid      = (state == S_EMIT) && nz[p];
  assign coef_level      = coef_valid ? cur : '0;
  assign coef_idx        = coef_valid ? p : '0;
  assign coef_run_before = coef_valid ? run : '0;
  assign coef_zeros_left = coef_valid ? zl : '0;
  assign coef_last       = coef_valid && is_last;

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Directed bench for cavlc_scan_ctrl: hand-computed summaries and beats for
// a set of fixed blocks, plus backpressure, reset and flush aborts.
module tb_cavlc_scan_ctrl;

  localparam int DATA_W   = 15;
  localparam int NUM_COEF = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       blk_valid;
  logic                       blk_ready;
  logic [NUM_COEF*DATA_W-1:0] blk_data;
  logic                       sum_valid;
  logic                       sum_ready;
  logic [4:0]                 total_coeff;
  logic [1:0]                 trailing_ones;
  logic [3:0]                 total_zeros;
  logic                       coef_valid;
  logic                       coef_ready;
  logic [DATA_W-1:0]          coef_level;
  logic [3:0]                 coef_idx;
  logic [3:0]                 coef_run_before;
  logic [3:0]                 coef_zeros_left;
  logic                       coef_last;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] c [NUM_COEF];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  cavlc_scan_ctrl #(.DATA_W(DATA_W), .NUM_COEF(NUM_COEF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready),
    .total_coeff(total_coeff), .trailing_ones(trailing_ones),
    .total_zeros(total_zeros),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_level(coef_level), .coef_idx(coef_idx),
    .coef_run_before(coef_run_before), .coef_zeros_left(coef_zeros_left),
    .coef_last(coef_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_c();
    for (int k = 0; k < NUM_COEF; k++) c[k] = '0;
  endtask

  // Handshake a block, then verify sum_valid first appears 17 cycles later.
  task automatic send_block();
    for (int k = 0; k < NUM_COEF; k++) blk_data[k*DATA_W +: DATA_W] = c[k];
    blk_valid = 1'b1;
    check("blk_ready_idle", 32'(blk_ready), 32'd1);
    step();
    blk_valid = 1'b0;
    check("blk_ready_busy", 32'(blk_ready), 32'd0);
    for (int i = 0; i < 15; i++) step();
    check("sum_not_yet", 32'(sum_valid), 32'd0);
    step();
    check("sum_valid_t17", 32'(sum_valid), 32'd1);
  endtask

  task automatic check_sum(input int tc, input int t1, input int tz);
    check("total_coeff", 32'(total_coeff), 32'(tc));
    check("trailing_ones", 32'(trailing_ones), 32'(t1));
    check("total_zeros", 32'(total_zeros), 32'(tz));
  endtask

  task automatic accept_sum();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  // Wait (bounded) for a beat, hold it for 'stall' cycles, then accept it.
  task automatic get_beat(input int idx, input logic [DATA_W-1:0] lvl, input int run,
                          input int zl, input int last, input int stall);
    int n;
    n = 0;
    while (!coef_valid && n < 20) begin
      step();
      n++;
    end
    check("beat_arrives", 32'(coef_valid), 32'd1);
    for (int s = 0; s <= stall; s++) begin
      check("coef_idx", 32'(coef_idx), 32'(idx));
      check("coef_level", 32'(coef_level), 32'(lvl));
      check("coef_run_before", 32'(coef_run_before), 32'(run));
      check("coef_zeros_left", 32'(coef_zeros_left), 32'(zl));
      check("coef_last", 32'(coef_last), 32'(last));
      if (s < stall) step();
    end
    coef_ready = 1'b1;
    step();
    coef_ready = 1'b0;
  endtask

  task automatic block_b();
    clear_c();
    c[1] = 15'd3; c[2] = 15'h7FFF; c[5] = 15'h7FFF; c[6] = 15'd1; c[8] = 15'd1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; blk_valid = 1'b0; blk_data = '0;
    sum_ready = 1'b0; coef_ready = 1'b0;
    clear_c();
    step();
    check("rst_blk_ready", 32'(blk_ready), 32'd1);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_coef_valid", 32'(coef_valid), 32'd0);
    check("rst_total_coeff", 32'(total_coeff), 32'd0);
    rst = 1'b0;
    step();

    // All-zero block: summary only, back to IDLE.
    clear_c();
    send_block();
    check_sum(0, 0, 0);
    accept_sum();
    check("zero_blk_ready", 32'(blk_ready), 32'd1);
    check("zero_no_beat", 32'(coef_valid), 32'd0);

    // Mixed block with a 4th +-1 and a zero below the lowest nonzero.
    block_b();
    send_block();
    check_sum(5, 3, 4);
    accept_sum();
    get_beat(8, 15'd1, 1, 4, 0, 0);
    get_beat(6, 15'd1, 0, 3, 0, 0);
    get_beat(5, 15'h7FFF, 2, 3, 0, 0);
    get_beat(2, 15'h7FFF, 0, 1, 0, 0);
    get_beat(1, 15'd3, 1, 1, 1, 0);
    check("b_done_ready", 32'(blk_ready), 32'd1);
    check("b_done_valid", 32'(coef_valid), 32'd0);

    // Non-+-1 breaks the trailing-ones run.
    clear_c();
    c[0] = 15'd1; c[1] = 15'd2; c[2] = 15'h7FFF;
    send_block();
    check_sum(3, 1, 0);
    accept_sum();
    get_beat(2, 15'h7FFF, 0, 0, 0, 0);
    get_beat(1, 15'd2, 0, 0, 0, 0);
    get_beat(0, 15'd1, 0, 0, 1, 0);

    // Full block of -1: total_coeff reaches 16.
    for (int k = 0; k < NUM_COEF; k++) c[k] = 15'h7FFF;
    send_block();
    check_sum(16, 3, 0);
    accept_sum();
    for (int i = 15; i >= 0; i--) get_beat(i, 15'h7FFF, 0, 0, (i == 0) ? 1 : 0, 0);
    check("full_done_ready", 32'(blk_ready), 32'd1);

    // Backpressure on summary then on beats.
    block_b();
    send_block();
    for (int s = 0; s < 5; s++) begin
      check("stall_sum_valid", 32'(sum_valid), 32'd1);
      check_sum(5, 3, 4);
      step();
    end
    check_sum(5, 3, 4);
    accept_sum();
    get_beat(8, 15'd1, 1, 4, 0, 2);
    get_beat(6, 15'd1, 0, 3, 0, 1);
    get_beat(5, 15'h7FFF, 2, 3, 0, 2);
    get_beat(2, 15'h7FFF, 0, 1, 0, 0);
    get_beat(1, 15'd3, 1, 1, 1, 3);
    check("bp_done_valid", 32'(coef_valid), 32'd0);

    // Asynchronous reset during SCAN cycle 7.
    clear_c();
    c[0] = 15'd1; c[1] = 15'd2; c[2] = 15'h7FFF;
    for (int k = 0; k < NUM_COEF; k++) blk_data[k*DATA_W +: DATA_W] = c[k];
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    #1;
    check("arst_blk_ready", 32'(blk_ready), 32'd1);
    check("arst_sum_valid", 32'(sum_valid), 32'd0);
    check("arst_coef_valid", 32'(coef_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("arst_no_sum", 32'(sum_valid), 32'd0);
    send_block();
    check_sum(3, 1, 0);
    accept_sum();
    get_beat(2, 15'h7FFF, 0, 0, 0, 0);
    get_beat(1, 15'd2, 0, 0, 0, 0);
    get_beat(0, 15'd1, 0, 0, 1, 0);

    // Flush after two beats; flush also beats a simultaneous coef_ready.
    block_b();
    send_block();
    accept_sum();
    get_beat(8, 15'd1, 1, 4, 0, 0);
    get_beat(6, 15'd1, 0, 3, 0, 0);
    flush = 1'b1;
    coef_ready = 1'b1;
    step();
    flush = 1'b0;
    coef_ready = 1'b0;
    check("flush_blk_ready", 32'(blk_ready), 32'd1);
    check("flush_coef_valid", 32'(coef_valid), 32'd0);
    check("flush_sum_valid", 32'(sum_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_quiet", 32'(coef_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
